// File: rtl/hififo_rr_tag_alloc.sv
// Read-request tag allocator: tags untagged reads, counts completion words per
// tag, frees tags on full payload, and caps in-flight reads at max_outstanding.
module hififo_rr_tag_alloc #(
  parameter int TAG_BITS     = 5,
  parameter int WORDS_PER_RR = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         out_addr,
  output logic [7:0]          out_tag,
  input  logic                rc_valid,
  input  logic [7:0]          rc_tag,
  input  logic [5:0]          rc_index,
  input  logic [TAG_BITS:0]   max_outstanding,
  output logic [TAG_BITS:0]   outstanding,
  output logic                err_unexpected
);

  localparam int NTAGS = 2 ** TAG_BITS;
  localparam logic [TAG_BITS:0] POOL_SIZE = (TAG_BITS + 1)'(NTAGS);
  localparam logic [6:0] WORDS_LAST = 7'(WORDS_PER_RR);

  // Handshake: a transfer happens on a cycle where valid && ready are both high
  // at the rising clock edge; a held out_valid keeps out_addr/out_tag stable.

  logic [NTAGS-1:0]    busy;
  logic [6:0]          cnt [NTAGS];

  logic [TAG_BITS-1:0] alloc_tag;
  logic                pool_full;
  logic [TAG_BITS:0]   max_eff;
  logic                accept;

  logic [TAG_BITS-1:0] rc_idx;
  logic                rc_in_range;
  logic                rc_ok;
  logic                rc_last;
  logic                free_tag;
  logic [6:0]          cnt_inc;

  // rc_index is informational; freeing relies only on the per-tag word count.
  logic                unused_rc_index;
  assign unused_rc_index = ^rc_index;

  // Lowest free tag from the registered bitmap; a tag freed this cycle is
  // still marked busy here, so it is only reused from the next cycle on.
  always_comb begin
    alloc_tag = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_tag = i[TAG_BITS-1:0];
    end
  end

  assign pool_full = &busy;
  assign max_eff   = (max_outstanding > POOL_SIZE) ? POOL_SIZE : max_outstanding;

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = (!out_valid || out_ready) && !pool_full && (outstanding < max_eff);
    end
  end

  assign accept = in_valid && in_ready;

  assign rc_idx      = rc_tag[TAG_BITS-1:0];
  assign rc_in_range = (rc_tag[7:TAG_BITS] == '0);
  assign rc_ok       = rc_valid && rc_in_range && busy[rc_idx];
  assign cnt_inc     = cnt[rc_idx] + 7'd1;
  assign rc_last     = (cnt_inc == WORDS_LAST);
  assign free_tag    = rc_ok && rc_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_tag   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_addr  <= in_addr;
      out_tag   <= {{(8 - TAG_BITS){1'b0}}, alloc_tag};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (free_tag) busy[rc_idx]    <= 1'b0;
      if (accept)   busy[alloc_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAGS; i++) cnt[i] <= '0;
    end else if (rc_ok) begin
      if (rc_last) cnt[rc_idx] <= '0;
      else         cnt[rc_idx] <= cnt_inc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, free_tag})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_unexpected <= 1'b0;
    end else if (rc_valid && !rc_ok) begin
      err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hififo_rr_tag_alloc.sv
// Directed bench for hififo_rr_tag_alloc: allocation order, completion freeing,
// output hold, unexpected completions, full-pool reuse and async reset.
module tb_hififo_rr_tag_alloc;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_addr;
  logic [7:0]  out_tag;
  logic        rc_valid;
  logic [7:0]  rc_tag;
  logic [5:0]  rc_index;
  logic [5:0]  max_outstanding;
  logic [5:0]  outstanding;
  logic        err_unexpected;

  int tests_run = 0;
  int tests_failed = 0;

  hififo_rr_tag_alloc #(.TAG_BITS(5), .WORDS_PER_RR(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_tag(out_tag),
    .rc_valid(rc_valid), .rc_tag(rc_tag), .rc_index(rc_index),
    .max_outstanding(max_outstanding), .outstanding(outstanding),
    .err_unexpected(err_unexpected)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // All driver tasks start and end just after a falling edge.
  task automatic req(input logic [63:0] addr, input logic [7:0] exp_tag);
    in_valid = 1'b1;
    in_addr  = addr;
    #1;
    check("req_in_ready", in_ready, 1);
    @(negedge clock);
    check("req_out_valid", out_valid, 1);
    check("req_out_tag", out_tag, exp_tag);
    check("req_out_addr", out_addr, addr);
    in_valid = 1'b0;
  endtask

  task automatic words(input logic [7:0] tag, input int n);
    for (int i = 0; i < n; i++) begin
      rc_valid = 1'b1;
      rc_tag   = tag;
      rc_index = i[5:0];
      @(negedge clock);
    end
    rc_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_addr = '0; out_ready = 1'b1;
    rc_valid = 1'b0; rc_tag = '0; rc_index = '0; max_outstanding = 6'd4;
    @(negedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_unexpected, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clock);
    reset = 1'b0;

    // Four back-to-back requests under max_outstanding=4
    req(64'h1000, 8'd0);
    req(64'h1080, 8'd1);
    req(64'h1100, 8'd2);
    req(64'h1180, 8'd3);
    check("limit_outstanding", outstanding, 4);
    in_valid = 1'b1; in_addr = 64'h1200;
    #1;
    check("limit_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clock);
    check("limit_out_valid_drop", out_valid, 0);
    check("limit_outstanding_hold", outstanding, 4);

    // 15 words leave tag 1 busy, the 16th frees it
    words(8'd1, 15);
    check("rc15_outstanding", outstanding, 4);
    words(8'd1, 1);
    check("rc16_outstanding", outstanding, 3);
    check("rc16_err", err_unexpected, 0);
    req(64'h2000, 8'd1);
    check("realloc_outstanding", outstanding, 4);

    // Free tag 0, then hold a tag-0 request with out_ready low
    words(8'd0, 16);
    check("free0_outstanding", outstanding, 3);
    max_outstanding = 6'd32;
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 64'hDEAD_BEEF_0000_0040;
    @(negedge clock);
    in_addr = 64'h3000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_out_tag", out_tag, 0);
      check("hold_out_addr", out_addr, 64'hDEAD_BEEF_0000_0040);
      check("hold_in_ready", in_ready, 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("hold_release_valid", out_valid, 0);
    check("hold_outstanding", outstanding, 4);

    // Unexpected completions: not-busy tag, then out-of-range tag
    words(8'd7, 1);
    check("unexp7_err", err_unexpected, 1);
    check("unexp7_outstanding", outstanding, 4);
    words(8'h40, 1);
    check("unexp40_err", err_unexpected, 1);
    check("unexp40_outstanding", outstanding, 4);
    repeat (3) @(negedge clock);
    check("err_sticky", err_unexpected, 1);

    // Fill the pool with max above the pool size; tag 4 is next lowest
    max_outstanding = 6'd63;
    for (int t = 4; t < 32; t++) req(64'h4000 + 64'(t) * 64'h80, 8'(t));
    check("full_outstanding", outstanding, 32);
    words(8'd0, 15);
    rc_valid = 1'b1; rc_tag = 8'd0; rc_index = 6'd15;
    in_valid = 1'b1; in_addr = 64'h9000;
    #1;
    check("full_free_in_ready", in_ready, 0);
    @(negedge clock);
    rc_valid = 1'b0;
    check("full_free_outstanding", outstanding, 31);
    check("full_free_out_valid", out_valid, 0);
    req(64'h9000, 8'd0);
    check("full_refill_outstanding", outstanding, 32);

    // Async reset with three busy tags and a pending output
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req(64'h100, 8'd0);
    req(64'h180, 8'd1);
    words(8'd1, 5);
    out_ready = 1'b0;
    req(64'h200, 8'd2);
    check("pre_rst_outstanding", outstanding, 3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_tag", out_tag, 0);
    check("arst_out_addr", out_addr, 0);
    check("arst_outstanding", outstanding, 0);
    check("arst_err", err_unexpected, 0);
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;

    max_outstanding = 6'd0;
    in_valid = 1'b1;
    #1;
    check("max0_in_ready", in_ready, 0);
    in_valid = 1'b0;
    max_outstanding = 6'd32;
    req(64'h500, 8'd0);
    req(64'h580, 8'd1);
    words(8'd1, 15);
    check("cnt_restart_15", outstanding, 2);
    words(8'd1, 1);
    check("cnt_restart_16", outstanding, 1);
    check("cnt_restart_err", err_unexpected, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
